// File: rtl/timer_periph.sv
// Memory-mapped 32-bit reload timer with sticky overflow interrupt and a free-running
// systick, sitting on the single-cycle core's peripheral bus (combinational read port).
module timer_periph #(
    parameter int unsigned PRESCALE = 1,
    parameter logic [31:0] BASE     = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irqout
);
    localparam logic [29:0] WA_TH   = BASE[31:2];
    localparam logic [29:0] WA_TL   = BASE[31:2] + 30'd1;
    localparam logic [29:0] WA_TCON = BASE[31:2] + 30'd2;
    localparam logic [29:0] WA_SYS  = BASE[31:2] + 30'd5;
    localparam logic [31:0] PS_LAST = PRESCALE - 32'd1;

    logic [31:0] r_th;
    logic [31:0] r_tl;
    logic [2:0]  r_tcon;
    logic [31:0] r_systick;
    logic [31:0] r_pcnt;

    logic [29:0] w_wa;
    logic        w_wr_th;
    logic        w_wr_tl;
    logic        w_wr_tcon;
    logic        w_tick;
    logic        w_ovf;
    logic        w_unused_addr;

    assign w_wa          = addr[31:2];
    assign w_unused_addr = ^addr[1:0];
    assign w_wr_th       = wr && (w_wa == WA_TH);
    assign w_wr_tl       = wr && (w_wa == WA_TL);
    assign w_wr_tcon     = wr && (w_wa == WA_TCON);

    // Tick and overflow are decided from pre-edge state; a TL write on the same edge suppresses the overflow.
    assign w_tick = r_tcon[0] && (r_pcnt == PS_LAST);
    assign w_ovf  = w_tick && (r_tl == 32'hFFFF_FFFF) && !w_wr_tl;

    assign irqout = r_tcon[1] & r_tcon[2];

    // Prescaler: restarts whenever the timer is stopped or TL is rewritten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcnt <= 32'h0;
        end else if (!r_tcon[0] || w_wr_tl || w_tick) begin
            r_pcnt <= 32'h0;
        end else begin
            r_pcnt <= r_pcnt + 32'd1;
        end
    end

    // Reload value; a reload on the write edge still sees the old TH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_th <= 32'h0;
        end else if (w_wr_th) begin
            r_th <= wdata;
        end
    end

    // Counter: software write has priority over a tick on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tl <= 32'h0;
        end else if (w_wr_tl) begin
            r_tl <= wdata;
        end else if (w_tick) begin
            r_tl <= (r_tl == 32'hFFFF_FFFF) ? r_th : (r_tl + 32'd1);
        end
    end

    // Control/status: overflow set beats a same-edge write-1-to-clear so no event is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcon <= 3'b000;
        end else begin
            if (w_wr_tcon) begin
                r_tcon[1:0] <= wdata[1:0];
            end
            if (w_ovf) begin
                r_tcon[2] <= 1'b1;
            end else if (w_wr_tcon && wdata[2]) begin
                r_tcon[2] <= 1'b0;
            end
        end
    end

    // Free-running systick, not writable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_systick <= 32'h0;
        end else begin
            r_systick <= r_systick + 32'd1;
        end
    end

    // Same-cycle read mux; unmapped or idle reads return zero.
    always_comb begin
        rdata = 32'h0;
        if (rd) begin
            case (w_wa)
                WA_TH:   rdata = r_th;
                WA_TL:   rdata = r_tl;
                WA_TCON: rdata = {29'h0, r_tcon};
                WA_SYS:  rdata = r_systick;
                default: rdata = 32'h0;
            endcase
        end else begin
            rdata = 32'h0;
        end
    end
endmodule

// File: tb/tb_timer_periph.sv
// Self-checking bench for timer_periph: two instances (PRESCALE 1 and 4) share one bus,
// expectations go through a scoreboard queue and are popped as the DUT answers.
module tb_timer_periph;
    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_SYS  = 32'h4000_0014;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd;
    logic        wr;
    logic        sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd0, wr0, rd1, wr1;
    logic [31:0] rdata0, rdata1, rdata;
    logic        irq0, irq1, irq;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb[$];
    logic [31:0] obs;
    logic [31:0] expv;

    always #5 clk = ~clk;

    assign rd0   = rd & ~sel;
    assign wr0   = wr & ~sel;
    assign rd1   = rd & sel;
    assign wr1   = wr & sel;
    assign rdata = sel ? rdata1 : rdata0;
    assign irq   = sel ? irq1 : irq0;

    timer_periph #(.PRESCALE(1), .BASE(32'h4000_0000)) u_dut (
        .clk(clk), .reset(reset), .rd(rd0), .wr(wr0), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .irqout(irq0)
    );

    timer_periph #(.PRESCALE(4), .BASE(32'h4000_0000)) u_dut4 (
        .clk(clk), .reset(reset), .rd(rd1), .wr(wr1), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .irqout(irq1)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(posedge clk);
        #1;
        wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        rd   = 1'b1;
        #1;
        d    = rdata;
        rd   = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        sb.push_back(32'h0); bus_read(A_TH, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL rst_init.th got=%h exp=%h", obs, expv); end
        sb.push_back(32'h0); bus_read(A_TL, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL rst_init.tl got=%h exp=%h", obs, expv); end
        sb.push_back(32'h0); bus_read(A_TCON, obs); expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL rst_init.tcon got=%h exp=%h", obs, expv); end
        sb.push_back(32'h0); bus_read(A_SYS, obs);  expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL rst_init.systick got=%h exp=%h", obs, expv); end
        sb.push_back(32'h0); obs = {31'h0, irq};    expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL rst_init.irq got=%h exp=%h", obs, expv); end
        bus_write(A_TH, 32'h0000_0005);
        bus_write(A_TL, 32'hFFFF_FFFF);
        bus_write(A_TCON, 32'h0000_0003);
        next_cycle();
        sb.push_back(32'h1); obs = {31'h0, irq};    expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL rst_pre.irq got=%h exp=%h", obs, expv); end
        sb.push_back(32'h5); bus_read(A_TL, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL rst_pre.tl got=%h exp=%h", obs, expv); end
        #1;
        reset = 1'b1;
        #1;
        sb.push_back(32'h0); obs = {31'h0, irq};    expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL rst_async.irq got=%h exp=%h", obs, expv); end
        sb.push_back(32'h0); bus_read(A_TH, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL rst_async.th got=%h exp=%h", obs, expv); end
        sb.push_back(32'h0); bus_read(A_TL, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL rst_async.tl got=%h exp=%h", obs, expv); end
        sb.push_back(32'h0); bus_read(A_TCON, obs); expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL rst_async.tcon got=%h exp=%h", obs, expv); end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reload();
        sel = 1'b0;
        bus_write(A_TH, 32'hFFFF_FFFC);
        bus_write(A_TL, 32'hFFFF_FFFE);
        bus_write(A_TCON, 32'h0000_0003);
        next_cycle();
        sb.push_back(32'hFFFF_FFFF); bus_read(A_TL, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL reload.tl1 got=%h exp=%h", obs, expv); end
        sb.push_back(32'h3);         bus_read(A_TCON, obs); expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL reload.tcon1 got=%h exp=%h", obs, expv); end
        sb.push_back(32'h0);         obs = {31'h0, irq};    expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL reload.irq1 got=%h exp=%h", obs, expv); end
        next_cycle();
        sb.push_back(32'hFFFF_FFFC); bus_read(A_TL, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL reload.tl2 got=%h exp=%h", obs, expv); end
        sb.push_back(32'h7);         bus_read(A_TCON, obs); expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL reload.tcon2 got=%h exp=%h", obs, expv); end
        sb.push_back(32'h1);         obs = {31'h0, irq};    expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL reload.irq2 got=%h exp=%h", obs, expv); end
    endtask

    task automatic test_w1c();
        sel = 1'b0;
        bus_write(A_TCON, 32'h0000_0003);
        sb.push_back(32'h7);         bus_read(A_TCON, obs); expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL w1c.keep_tcon got=%h exp=%h", obs, expv); end
        sb.push_back(32'h1);         obs = {31'h0, irq};    expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL w1c.keep_irq got=%h exp=%h", obs, expv); end
        bus_write(A_TCON, 32'h0000_0007);
        sb.push_back(32'h3);         bus_read(A_TCON, obs); expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL w1c.clr_tcon got=%h exp=%h", obs, expv); end
        sb.push_back(32'h0);         obs = {31'h0, irq};    expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL w1c.clr_irq got=%h exp=%h", obs, expv); end
        sb.push_back(32'hFFFF_FFFE); bus_read(A_TL, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL w1c.tl_a got=%h exp=%h", obs, expv); end
        next_cycle();
        sb.push_back(32'hFFFF_FFFF); bus_read(A_TL, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL w1c.tl_b got=%h exp=%h", obs, expv); end
        bus_write(A_TCON, 32'h0000_0007);
        sb.push_back(32'h7);         bus_read(A_TCON, obs); expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL w1c.set_wins got=%h exp=%h", obs, expv); end
        sb.push_back(32'hFFFF_FFFC); bus_read(A_TL, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL w1c.tl_reload got=%h exp=%h", obs, expv); end
        bus_write(A_TCON, 32'h0000_0004);
        sb.push_back(32'hFFFF_FFFD); bus_read(A_TL, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL w1c.dis_tick got=%h exp=%h", obs, expv); end
        sb.push_back(32'h0);         bus_read(A_TCON, obs); expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL w1c.dis_tcon got=%h exp=%h", obs, expv); end
        next_cycle();
        sb.push_back(32'hFFFF_FFFD); bus_read(A_TL, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL w1c.dis_hold got=%h exp=%h", obs, expv); end
    endtask

    task automatic test_prescale();
        sel = 1'b1;
        bus_write(A_TL, 32'h0);
        bus_write(A_TCON, 32'h0000_0001);
        repeat (3) next_cycle();
        sb.push_back(32'h0); bus_read(A_TL, obs); expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL ps.tl_3 got=%h exp=%h", obs, expv); end
        next_cycle();
        sb.push_back(32'h1); bus_read(A_TL, obs); expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL ps.tl_4 got=%h exp=%h", obs, expv); end
        repeat (3) next_cycle();
        sb.push_back(32'h1); bus_read(A_TL, obs); expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL ps.tl_7 got=%h exp=%h", obs, expv); end
        next_cycle();
        sb.push_back(32'h2); bus_read(A_TL, obs); expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL ps.tl_8 got=%h exp=%h", obs, expv); end
        bus_write(A_TCON, 32'h0);
        repeat (8) next_cycle();
        sb.push_back(32'h2); bus_read(A_TL, obs); expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL ps.hold got=%h exp=%h", obs, expv); end
        sel = 1'b0;
    endtask

    task automatic test_collision();
        sel = 1'b0;
        bus_write(A_TH, 32'h0000_0064);
        bus_write(A_TL, 32'hFFFF_FFFE);
        bus_write(A_TCON, 32'h0000_0001);
        next_cycle();
        sb.push_back(32'hFFFF_FFFF); bus_read(A_TL, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL col.pre_tl got=%h exp=%h", obs, expv); end
        bus_write(A_TL, 32'h0000_0005);
        sb.push_back(32'h5);         bus_read(A_TL, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL col.tl_wins got=%h exp=%h", obs, expv); end
        sb.push_back(32'h1);         bus_read(A_TCON, obs); expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL col.no_ovf got=%h exp=%h", obs, expv); end
        bus_write(A_TL, 32'hFFFF_FFFE);
        next_cycle();
        bus_write(A_TH, 32'h0000_0009);
        sb.push_back(32'h64);        bus_read(A_TL, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL col.old_th got=%h exp=%h", obs, expv); end
        sb.push_back(32'h9);         bus_read(A_TH, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL col.new_th got=%h exp=%h", obs, expv); end
        sb.push_back(32'h5);         bus_read(A_TCON, obs); expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL col.ovf_tcon got=%h exp=%h", obs, expv); end
        sb.push_back(32'h0);         obs = {31'h0, irq};    expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL col.irq_masked got=%h exp=%h", obs, expv); end
        bus_write(A_TCON, 32'h0000_0004);
        sb.push_back(32'h65);        bus_read(A_TL, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL col.dis_tl got=%h exp=%h", obs, expv); end
    endtask

    task automatic test_map();
        sel = 1'b0;
        next_cycle();
        sb.push_back(32'h0);  bus_read(A_TH + 32'h0C, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL map.rd_0c got=%h exp=%h", obs, expv); end
        sb.push_back(32'h0);  bus_read(A_TH + 32'h20, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL map.rd_20 got=%h exp=%h", obs, expv); end
        sb.push_back(32'h0);  bus_read(32'hC000_0000, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL map.rd_alias got=%h exp=%h", obs, expv); end
        sb.push_back(32'h9);  bus_read(A_TH + 32'h03, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL map.rd_byte got=%h exp=%h", obs, expv); end
        addr = A_TH; rd = 1'b0; #1;
        sb.push_back(32'h0);  obs = rdata;                    expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL map.idle got=%h exp=%h", obs, expv); end
        bus_write(A_TH + 32'h0C, 32'hFFFF_FFFF);
        sb.push_back(32'h9);  bus_read(A_TH, obs);            expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL map.wr_ign_th got=%h exp=%h", obs, expv); end
        sb.push_back(32'h0);  bus_read(A_TCON, obs);          expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL map.wr_ign_tcon got=%h exp=%h", obs, expv); end
        next_cycle();
        force u_dut.r_systick = 32'hFFFF_FFFE;
        #1;
        release u_dut.r_systick;
        sb.push_back(32'hFFFF_FFFE); bus_read(A_SYS, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL map.sys_pre got=%h exp=%h", obs, expv); end
        bus_write(A_SYS, 32'h0000_1234);
        sb.push_back(32'hFFFF_FFFF); bus_read(A_SYS, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL map.sys_wr_ign got=%h exp=%h", obs, expv); end
        next_cycle();
        sb.push_back(32'h0);         bus_read(A_SYS, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL map.sys_wrap got=%h exp=%h", obs, expv); end
        next_cycle();
        sb.push_back(32'h1);         bus_read(A_SYS, obs);   expv = sb.pop_front(); total++; if (obs !== expv) begin bad++; $display("FAIL map.sys_inc got=%h exp=%h", obs, expv); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        reset = 1'b1;
        rd    = 1'b0;
        wr    = 1'b0;
        sel   = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_reload();
        test_w1c();
        test_prescale();
        test_collision();
        test_map();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
